// File: rtl/fp_sign_resolver_pkg.sv
// Shared definitions for the FP add/sub result sign resolver: rounding-mode
// encodings and the canonical quiet-NaN pattern builder.
package fp_sign_resolver_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RTP = 2'b10,
        RM_RTN = 2'b11
    } rmode_e;

    // Stage-1 flag bits stored alongside the magnitude:
    // sign_a, sb_eff, eff_sub, swap, zero_res, nan_res, rmode[1:0]
    localparam int S1_FLAG_W = 8;

    // Positive sign, all-ones exponent, mantissa MSB set, rest zero.
    function automatic logic [63:0] canon_qnan(input int w, input int ew);
        logic [63:0] exp_ones;
        exp_ones = (64'd1 << ew) - 64'd1;
        return (exp_ones << (w - 1 - ew)) | (64'd1 << (w - 2 - ew));
    endfunction

endpackage

// File: rtl/fp_sign_resolver_if.sv
// Upstream (core result) and downstream (result bus) handshake bundle for
// the sign resolver; slave is the resolver side, master the environment side.
interface fp_sign_resolver_if
    import fp_sign_resolver_pkg::*;
#(
    parameter int W = 32
);
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic          sign_a;
    logic          sign_b;
    logic          swap;
    logic          zero_res;
    logic          nan_res;
    rmode_e        rmode;
    logic [W-2:0]  Data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Fixed_Data;

    modport slave (
        input  in_valid, op_sub, sign_a, sign_b, swap, zero_res, nan_res,
        input  rmode, Data, out_ready,
        output in_ready, out_valid, Fixed_Data
    );

    modport master (
        output in_valid, op_sub, sign_a, sign_b, swap, zero_res, nan_res,
        output rmode, Data, out_ready,
        input  in_ready, out_valid, Fixed_Data
    );

endinterface

// File: rtl/fp_sign_resolver_pipe_stage.sv
// Valid/ready register slice: holds one payload, accepts a new one whenever it
// is empty or its current payload leaves in the same cycle.
module fp_sign_resolver_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [PW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [PW-1:0] data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] data_q;
    logic [PW-1:0] data_d;
    logic          load_s;

    assign ready_o = !valid_q || ready_i;
    assign load_s  = valid_i && ready_o;

    // Next state: refill or drain when the slot opens, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (load_s) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Slot register; payload is only written on a load so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {PW{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fp_sign_resolver.sv
// Reconstructs the IEEE-754 sign of an add/sub magnitude result (signed zero,
// NaN, swapped operands) in a two-slot valid/ready pipeline.
module fp_sign_resolver
    import fp_sign_resolver_pkg::*;
#(
    parameter int W  = 32,
    parameter int EW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_sign_resolver_if.slave      bus
);

    localparam int             MW        = W - 1;
    localparam int             S1W       = MW + S1_FLAG_W;
    localparam logic [63:0]    QNAN_WIDE = canon_qnan(W, EW);
    localparam logic [W-1:0]   QNAN      = QNAN_WIDE[W-1:0];

    logic           sb_eff_s;
    logic           eff_sub_s;
    logic [S1W-1:0] s1_in_s;
    logic [S1W-1:0] s1_out_s;
    logic           s1_valid_s;
    logic           s2_ready_s;
    logic [W-1:0]   res_s;

    logic           s1_sign_a_s;
    logic           s1_sb_eff_s;
    logic           s1_eff_sub_s;
    logic           s1_swap_s;
    logic           s1_zero_s;
    logic           s1_nan_s;
    logic [1:0]     s1_rmode_s;
    logic [MW-1:0]  s1_data_s;

    // B's sign as the core actually added it, and whether magnitudes were subtracted.
    assign sb_eff_s  = bus.sign_b ^ bus.op_sub;
    assign eff_sub_s = bus.sign_a ^ sb_eff_s;

    assign s1_in_s = {bus.sign_a, sb_eff_s, eff_sub_s, bus.swap,
                      bus.zero_res, bus.nan_res, bus.rmode, bus.Data};

    fp_sign_resolver_pipe_stage #(
        .PW (S1W)
    ) u_stage1 (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (bus.in_valid),
        .ready_o (bus.in_ready),
        .data_i  (s1_in_s),
        .valid_o (s1_valid_s),
        .ready_i (s2_ready_s),
        .data_o  (s1_out_s)
    );

    assign {s1_sign_a_s, s1_sb_eff_s, s1_eff_sub_s, s1_swap_s,
            s1_zero_s, s1_nan_s, s1_rmode_s, s1_data_s} = s1_out_s;

    // Sign resolution: NaN wins, then exact-zero rules, then the larger operand's sign.
    always_comb begin
        res_s = {s1_sign_a_s, s1_data_s};
        if (s1_nan_s) begin
            res_s = QNAN;
        end else if (s1_zero_s && s1_eff_sub_s) begin
            // x - x is +0 except when rounding toward negative infinity
            res_s = {(s1_rmode_s == RM_RTN), {MW{1'b0}}};
        end else if (s1_zero_s) begin
            res_s = {s1_sign_a_s, {MW{1'b0}}};
        end else begin
            res_s = {(s1_swap_s ? s1_sb_eff_s : s1_sign_a_s), s1_data_s};
        end
    end

    fp_sign_resolver_pipe_stage #(
        .PW (W)
    ) u_stage2 (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (s1_valid_s),
        .ready_o (s2_ready_s),
        .data_i  (res_s),
        .valid_o (bus.out_valid),
        .ready_i (bus.out_ready),
        .data_o  (bus.Fixed_Data)
    );

endmodule

// File: tb/tb_fp_sign_resolver.sv
// Scoreboard bench for fp_sign_resolver: directed vectors push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_fp_sign_resolver;
    import fp_sign_resolver_pkg::*;

    localparam int W  = 32;
    localparam int EW = 8;

    typedef struct {
        logic [W-1:0] data;
        int           t_edge;
        bit           chk_lat;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    fp_sign_resolver_if #(.W(W)) bus ();

    fp_sign_resolver #(.W(W), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Present one vector from a negedge until accepted; returns at a negedge.
    task automatic send(input int id, input bit a, input bit b, input bit sub, input bit sw,
                        input bit z, input bit n, input rmode_e rm, input logic [W-2:0] d,
                        input logic [W-1:0] exp_v, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus.sign_a   = a;
        bus.sign_b   = b;
        bus.op_sub   = sub;
        bus.swap     = sw;
        bus.zero_res = z;
        bus.nan_res  = n;
        bus.rmode    = rm;
        bus.Data     = d;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            #2;
            if (bus.in_ready) begin
                e.data    = exp_v;
                e.t_edge  = cyc + 1;
                e.chk_lat = lat;
                e.id      = id;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check($sformatf("send_timeout_%0d", id), 64'(done), 64'd1);
        bus.in_valid = 1'b0;
        bus.Data     = 31'h7ABC_DEF0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && sb_q.size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        check(name, 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: compares each transferred result and checks stall stability.
    initial begin : monitor
        bit           hold_v;
        logic [W-1:0] hold_d;
        exp_t         e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                hold_v = 1'b0;
            end else if (bus.out_valid) begin
                if (hold_v) check("hold_stable", 64'(bus.Fixed_Data), 64'(hold_d));
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h required no output", bus.Fixed_Data);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("result_%0d", e.id), 64'(bus.Fixed_Data), 64'(e.data));
                        if (e.chk_lat) check($sformatf("latency_%0d", e.id), 64'(cyc - e.t_edge), 64'd1);
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_d = bus.Fixed_Data;
                end
            end else begin
                if (hold_v) check("valid_held", 64'(bus.out_valid), 64'd1);
                hold_v = 1'b0;
            end
        end
    end

    initial begin : stim
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.swap      = 1'b0;
        bus.zero_res  = 1'b0;
        bus.nan_res   = 1'b0;
        bus.rmode     = RM_RNE;
        bus.Data      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_fixed_data", 64'(bus.Fixed_Data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors, no backpressure: id, sa, sb, sub, swap, zero, nan, rm, Data, expected
        send(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RM_RNE, 31'h4000_0000, 32'hC000_0000, 1'b1);
        send(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RM_RNE, 31'h4080_0000, 32'hC080_0000, 1'b1);
        send(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RM_RNE, 31'h0000_0000, 32'h0000_0000, 1'b1);
        send(4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RM_RTZ, 31'h0000_0000, 32'h0000_0000, 1'b1);
        send(5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RM_RTP, 31'h0000_0000, 32'h0000_0000, 1'b1);
        send(6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, RM_RTN, 31'h0000_0000, 32'h8000_0000, 1'b1);
        send(7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RM_RNE, 31'h0000_0000, 32'h8000_0000, 1'b1);
        send(8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RM_RTN, 31'h0001_2345, 32'h7FC0_0000, 1'b1);
        send(9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RM_RNE, 31'h3FC0_0000, 32'hBFC0_0000, 1'b1);
        drain("drain_directed");

        // Backpressure: four back-to-back inputs while the result bus stalls for 4 cycles.
        bus.out_ready = 1'b0;
        fork
            begin
                send(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RM_RNE, 31'h3F80_0000, 32'h3F80_0000, 1'b0);
                send(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RM_RNE, 31'h4040_0000, 32'hC040_0000, 1'b0);
                send(12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RM_RNE, 31'h40A0_0000, 32'hC0A0_0000, 1'b0);
                send(13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, RM_RNE, 31'h4100_0000, 32'h4100_0000, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                #2;
                check("in_ready_full", 64'(bus.in_ready), 64'd0);
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with two results in flight: both must vanish.
        bus.out_ready = 1'b0;
        send(14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RM_RNE, 31'h3F80_0000, 32'h3F80_0000, 1'b0);
        send(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RM_RNE, 31'h4040_0000, 32'hC040_0000, 1'b0);
        #1;
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_fixed_data", 64'(bus.Fixed_Data), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        check("in_ready_after_midrst", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        send(16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RM_RNE, 31'h40E0_0000, 32'h40E0_0000, 1'b1);
        drain("drain_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
